// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//   Shared definitions for the processing-element traffic engine:
//   flit width and field positions, FSM state encoding, LFSR taps and
//   the LFSR step helper.
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W = 20;

  // Flit layout: {dst, src, seq, payload}
  localparam int DST_HI = 19;
  localparam int DST_LO = 16;
  localparam int SRC_HI = 15;
  localparam int SRC_LO = 12;
  localparam int SEQ_HI = 11;
  localparam int SEQ_LO = 8;
  localparam int PAY_HI = 7;
  localparam int PAY_LO = 0;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_GAP_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } pe_state_e;

  // Fibonacci form: shift left, parity of tapped bits enters at bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pe_credit_counter.sv
// ---------------------------------------------------------------------------
// pe_credit_counter
//   Tracks free slots in the router's local input buffer.
//   Ports:
//     clk, rst_n   clock / asynchronous active-low reset
//     inc_i        credit returned by the router (one slot freed)
//     dec_i        flit injected (one slot consumed)
//     avail_o      at least one credit available
//     overflow_o   credit returned while already full (counter saturates)
// ---------------------------------------------------------------------------
module pe_credit_counter #(
  parameter int CREDITS = 4,
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o,
  output logic overflow_o
);

  localparam logic [CW-1:0] MAX_CREDIT = CW'(CREDITS);

  logic [CW-1:0] credit_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= MAX_CREDIT;
    end else begin
      case ({inc_i, dec_i})
        2'b10:   if (credit_q != MAX_CREDIT) credit_q <= credit_q + 1'b1;
        2'b01:   if (credit_q != '0)         credit_q <= credit_q - 1'b1;
        default: credit_q <= credit_q;  // idle, or return and consume cancel
      endcase
    end
  end

  assign avail_o    = (credit_q != '0);
  assign overflow_o = inc_i && !dec_i && (credit_q == MAX_CREDIT);

endmodule

// File: rtl/pe_traffic_engine.sv
// ---------------------------------------------------------------------------
// pe_traffic_engine
//   Traffic source/sink on a router's local port. Injects NUM_PKTS
//   single-flit packets under credit flow control, sinks every ejected
//   flit and keeps tx/rx/error statistics.
//   Ports:
//     clk        clock, rising edge
//     RST        asynchronous reset, active-low
//     position   own node id (static after reset)
//     enable     level; start/continue injection, low freezes injection
//     datain     ejected flit from router, qualified by in_valid
//     in_valid   ejected flit valid (always accepted)
//     ci         credit return pulse
//     dataout    injected flit (registered)
//     out_valid  dataout valid
//     tx_count   flits injected (saturating)
//     rx_count   flits ejected (saturating)
//     err        sticky: misroute, credit overflow, sequence error
//     done       all NUM_PKTS flits sent
//   Build option: define SEQ_CHECK_EN to add per-source sequence checking.
// ---------------------------------------------------------------------------
module pe_traffic_engine
  import noc_pkg::*;
#(
  parameter int         CREDITS   = 4,
  parameter int         NUM_PKTS  = 16,
  parameter int         GAP       = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [3:0]        position,
  input  logic              enable,
  input  logic [FLIT_W-1:0] datain,
  input  logic              in_valid,
  input  logic              ci,
  output logic [FLIT_W-1:0] dataout,
  output logic              out_valid,
  output logic [7:0]        tx_count,
  output logic [7:0]        rx_count,
  output logic              err,
  output logic              done
);

  pe_state_e         state_q, state_d;
  logic [3:0]        gap_q, gap_d;
  logic [7:0]        lfsr_q;
  logic [7:0]        tx_q, rx_q;
  logic [FLIT_W-1:0] dout_q;
  logic              ov_q;
  logic              err_q;

  logic              credit_avail;
  logic              credit_ovf;
  logic              fire;
  logic [3:0]        dst_raw, dst;
  logic [FLIT_W-1:0] flit_d;
  logic              misroute;
  logic              seq_err;

  pe_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk        (clk),
    .rst_n      (RST),
    .inc_i      (ci),
    .dec_i      (fire),
    .avail_o    (credit_avail),
    .overflow_o (credit_ovf)
  );

  // A flit is launched on the edge that ends a SEND cycle with credit.
  assign fire = (state_q == ST_SEND) && enable && credit_avail;

  // Never address ourselves: bump to the next node id.
  assign dst_raw = lfsr_q[3:0];
  assign dst     = (dst_raw == position) ? position + 4'd1 : dst_raw;
  assign flit_d  = {dst, position, tx_q[3:0], lfsr_q};

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_SEND;
      ST_SEND: begin
        if (fire) begin
          if (tx_q + 8'd1 == 8'(NUM_PKTS)) begin
            state_d = ST_DONE;
          end else if (GAP == 0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_GAP_WAIT;
            gap_d   = '0;
          end
        end
      end
      ST_GAP_WAIT: begin
        if (enable) begin
          if (gap_q == 4'(GAP - 1)) state_d = ST_SEND;
          else                      gap_d   = gap_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Injection datapath: flit and valid are registered together.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      dout_q <= '0;
      ov_q   <= 1'b0;
      tx_q   <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      ov_q <= fire;
      if (fire) begin
        dout_q <= flit_d;
        lfsr_q <= lfsr_step(lfsr_q);
        if (tx_q != 8'hFF) tx_q <= tx_q + 8'd1;
      end
    end
  end

  assign misroute = in_valid && (datain[DST_HI:DST_LO] != position);

`ifdef SEQ_CHECK_EN
  logic [3:0] exp_seq_q [16];
  logic [3:0] rx_src, rx_seq;

  assign rx_src  = datain[SRC_HI:SRC_LO];
  assign rx_seq  = datain[SEQ_HI:SEQ_LO];
  assign seq_err = in_valid && (rx_seq != exp_seq_q[rx_src]);

  // NOTE: this small table is reset explicitly because a restart must not
  // inherit stale sequence numbers; large data memories normally are not.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) exp_seq_q[i] <= '0;
    end else if (in_valid) begin
      // Resynchronise on every flit so one loss reports once.
      exp_seq_q[rx_src] <= rx_seq + 4'd1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  // Receive side: the sink only inspects the destination field in the
  // default build; the remaining fields are intentionally ignored.
  logic unused_rx_fields;
  assign unused_rx_fields = ^datain[SEQ_HI:PAY_LO] ^ ^datain[SRC_HI:SRC_LO];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rx_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (in_valid && rx_q != 8'hFF) rx_q <= rx_q + 8'd1;
      if (credit_ovf || misroute || seq_err) err_q <= 1'b1;
    end
  end

  assign dataout   = dout_q;
  assign out_valid = ov_q;
  assign tx_count  = tx_q;
  assign rx_count  = rx_q;
  assign err       = err_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pe_traffic_engine.sv
// ---------------------------------------------------------------------------
// tb_pe_traffic_engine
//   Directed bench for pe_traffic_engine (position 5, 4 credits, GAP 0,
//   16 packets, seed A5): injection under credit, credit return, full run,
//   credit overflow, enable freeze, async reset, receive vectors.
// ---------------------------------------------------------------------------
module tb_pe_traffic_engine;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  position = 4'd5;
  logic        enable = 1'b0;
  logic [19:0] datain = '0;
  logic        in_valid = 1'b0;
  logic        ci = 1'b0;
  logic [19:0] dataout;
  logic        out_valid;
  logic [7:0]  tx_count;
  logic [7:0]  rx_count;
  logic        err;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_traffic_engine #(
    .CREDITS   (4),
    .NUM_PKTS  (16),
    .GAP       (0),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .position  (position),
    .enable    (enable),
    .datain    (datain),
    .in_valid  (in_valid),
    .ci        (ci),
    .dataout   (dataout),
    .out_valid (out_valid),
    .tx_count  (tx_count),
    .rx_count  (rx_count),
    .err       (err),
    .done      (done)
  );

  typedef struct {
    logic [3:0] dst;
    logic [3:0] seq;
    logic [7:0] pay;
  } flit_exp_t;

  typedef struct {
    logic        vld;
    logic [19:0] data;
    logic [7:0]  exp_rx;
    logic        exp_err;
  } rx_vec_t;

  flit_exp_t   inj_tab [5];
  rx_vec_t     rx_tab  [7];
  logic [19:0] got [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST      = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    ci       = 1'b0;
    datain   = '0;
    position = 4'd5;
    repeat (2) @(negedge clk);
    RST = 1'b1;
  endtask

  function automatic logic [7:0] model_lfsr(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  initial begin
    logic [1:0] pipe;
    logic [7:0] m;
    logic [3:0] edst;
    int seen;

    // First five flits from seed A5, computed by hand.
    inj_tab[0] = '{dst: 4'h6, seq: 4'h0, pay: 8'hA5};
    inj_tab[1] = '{dst: 4'hA, seq: 4'h1, pay: 8'h4A};
    inj_tab[2] = '{dst: 4'h6, seq: 4'h2, pay: 8'h95};
    inj_tab[3] = '{dst: 4'hA, seq: 4'h3, pay: 8'h2A};
    inj_tab[4] = '{dst: 4'h4, seq: 4'h4, pay: 8'h54};

    // Receive vectors at position 5: {dst,src,seq,payload}
    rx_tab[0] = '{vld: 1'b0, data: 20'h5_2_0_11, exp_rx: 8'd0, exp_err: 1'b0};
    rx_tab[1] = '{vld: 1'b1, data: 20'h5_2_0_11, exp_rx: 8'd1, exp_err: 1'b0};
    rx_tab[2] = '{vld: 1'b1, data: 20'h5_2_1_22, exp_rx: 8'd2, exp_err: 1'b0};
    rx_tab[3] = '{vld: 1'b1, data: 20'h5_7_0_33, exp_rx: 8'd3, exp_err: 1'b0};
`ifdef SEQ_CHECK_EN
    rx_tab[4] = '{vld: 1'b1, data: 20'h5_2_3_44, exp_rx: 8'd4, exp_err: 1'b1};
`else
    rx_tab[4] = '{vld: 1'b1, data: 20'h5_2_3_44, exp_rx: 8'd4, exp_err: 1'b0};
`endif
    rx_tab[5] = '{vld: 1'b1, data: 20'h3_1_0_55, exp_rx: 8'd5, exp_err: 1'b1};
    rx_tab[6] = '{vld: 1'b0, data: 20'h3_1_0_55, exp_rx: 8'd5, exp_err: 1'b1};

    // ---- reset state
    do_reset();
    check("rst_dataout",   32'(dataout),   32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_tx",        32'(tx_count),  32'd0);
    check("rst_rx",        32'(rx_count),  32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_done",      32'(done),      32'd0);

    // ---- inject with no credit return: exactly CREDITS flits
    enable = 1'b1;
    got.delete();
    repeat (12) begin
      tick();
      if (out_valid) got.push_back(dataout);
    end
    check("inj_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      check($sformatf("inj%0d_dst", i), 32'(got[i][19:16]), 32'(inj_tab[i].dst));
      check($sformatf("inj%0d_src", i), 32'(got[i][15:12]), 32'd5);
      check($sformatf("inj%0d_seq", i), 32'(got[i][11:8]),  32'(inj_tab[i].seq));
      check($sformatf("inj%0d_pay", i), 32'(got[i][7:0]),   32'(inj_tab[i].pay));
    end
    check("inj_tx",     32'(tx_count),               32'd4);
    check("inj_ov_low", 32'(out_valid),              32'd0);
    check("inj_credit", 32'(dut.u_credit.credit_q),  32'd0);

    // ---- one credit back: exactly one more flit
    got.delete();
    ci = 1'b1;
    tick();
    ci = 1'b0;
    if (out_valid) got.push_back(dataout);
    repeat (10) begin
      tick();
      if (out_valid) got.push_back(dataout);
    end
    check("cr_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      check("cr_dst", 32'(got[0][19:16]), 32'(inj_tab[4].dst));
      check("cr_seq", 32'(got[0][11:8]),  32'(inj_tab[4].seq));
      check("cr_pay", 32'(got[0][7:0]),   32'(inj_tab[4].pay));
    end
    check("cr_tx", 32'(tx_count), 32'd5);

    // ---- full run: credit returned 2 cycles after each flit
    do_reset();
    enable = 1'b1;
    pipe   = '0;
    got.delete();
    for (int c = 0; c < 300 && !(done && pipe == 2'b00); c++) begin
      tick();
      if (out_valid) got.push_back(dataout);
      ci   = pipe[1];
      pipe = {pipe[0], out_valid};
    end
    tick();
    ci = 1'b0;
    tick();
    check("run_count", 32'(got.size()), 32'd16);
    m = 8'hA5;
    for (int i = 0; i < got.size() && i < 16; i++) begin
      edst = (m[3:0] == 4'd5) ? 4'd6 : m[3:0];
      check($sformatf("run%0d_src", i), 32'(got[i][15:12]), 32'd5);
      check($sformatf("run%0d_seq", i), 32'(got[i][11:8]),  32'(i));
      check($sformatf("run%0d_dst", i), 32'(got[i][19:16]), 32'(edst));
      check($sformatf("run%0d_pay", i), 32'(got[i][7:0]),   32'(m));
      m = model_lfsr(m);
    end
    check("run_done",   32'(done),                  32'd1);
    check("run_err",    32'(err),                   32'd0);
    check("run_tx",     32'(tx_count),              32'd16);
    check("run_ov",     32'(out_valid),             32'd0);
    check("run_credit", 32'(dut.u_credit.credit_q), 32'd4);

    // ---- credit overflow at full credit
    ci = 1'b1;
    tick();
    ci = 1'b0;
    tick();
    check("ovf_err",    32'(err),                   32'd1);
    check("ovf_credit", 32'(dut.u_credit.credit_q), 32'd4);
    check("ovf_done",   32'(done),                  32'd1);

    // ---- enable low freezes injection
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 20 && tx_count != 8'd2; c++) tick();
    check("frz_tx_start", 32'(tx_count), 32'd2);
    enable = 1'b0;
    seen = 0;
    repeat (5) begin
      tick();
      if (out_valid) seen++;
    end
    check("frz_no_flit", 32'(seen),     32'd0);
    check("frz_tx_held", 32'(tx_count), 32'd2);
    enable = 1'b1;
    tick();
    check("frz_resume_tx", 32'(tx_count),  32'd3);
    check("frz_resume_ov", 32'(out_valid), 32'd1);

    // ---- asynchronous reset mid-SEND, no clock edge needed
    #2;
    RST = 1'b0;
    #1;
    check("arst_dataout",   32'(dataout),   32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_tx",        32'(tx_count),  32'd0);
    check("arst_err",       32'(err),       32'd0);
    check("arst_done",      32'(done),      32'd0);
    @(negedge clk);
    enable = 1'b0;
    RST    = 1'b1;

    // ---- receive vectors: misroute and sequence checking
    foreach (rx_tab[i]) begin
      in_valid = rx_tab[i].vld;
      datain   = rx_tab[i].data;
      tick();
      check($sformatf("rx%0d_count", i), 32'(rx_count), 32'(rx_tab[i].exp_rx));
      check($sformatf("rx%0d_err", i),   32'(err),      32'(rx_tab[i].exp_err));
    end
    in_valid = 1'b0;

    // ---- rx_count saturates at 255
    in_valid = 1'b1;
    datain   = 20'h5_9_0_00;
    repeat (260) tick();
    in_valid = 1'b0;
    tick();
    check("rx_sat", 32'(rx_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
